medicine_machine_core: RTL and testbench

- Four-compartment medication-box controller.
- Each compartment has a fixed dosing period. When a dose falls due, the block raises that compartment's shouldEat bit.
- The patient acknowledges a dose by pressing the matching button.
- Any dose left unacknowledged past a timeout is escalated on notify.
- Sits between the front-panel buttons, the LED/buzzer drivers and a caregiver-notification link.

---
 rtl/medicine_machine_core_pkg.sv | 19 +
 rtl/medicine_machine_core_dose_timer.sv | 28 ++
 rtl/medicine_machine_core.sv | 101 ++++++++++
 tb/tb_medicine_machine_core.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/medicine_machine_core_pkg.sv
// Shared definitions for the medication-box controller: FSM encodings and
// default dosing periods / escalation timeout.
package medicine_machine_core_pkg;

  typedef logic [1:0] state_t;

  localparam state_t CHECK_TIME = 2'd0;
  localparam state_t DRUG_ALARM = 2'd1;
  localparam state_t DONE       = 2'd2;
  localparam state_t NOTIFY     = 2'd3;

  localparam int DEF_P0      = 4;
  localparam int DEF_P1      = 6;
  localparam int DEF_P2      = 8;
  localparam int DEF_P3      = 12;
  localparam int DEF_TIMEOUT = 4;
  localparam int DEF_CW      = 8;

endpackage

// File: rtl/medicine_machine_core_dose_timer.sv
// Free-running period down-counter; due is high on the cycle the count sits
// at zero, and the counter reloads on that same edge so it never underflows.
module dose_timer #(
  parameter int CW     = 8,
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  output logic due
);

  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] rem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg <= RELOAD;
    end else if (rem_reg == '0) begin
      rem_reg <= RELOAD;
    end else begin
      rem_reg <= rem_reg - 1'b1;
    end
  end

  assign due = (rem_reg == '0);

endmodule

// File: rtl/medicine_machine_core.sv
// Four-compartment medication controller: per-compartment dose timers feed a
// pending register (shouldEat) and an alarm/escalation FSM driving notify.
module medicine_machine_core
  import medicine_machine_core_pkg::*;
#(
  parameter int P0      = DEF_P0,
  parameter int P1      = DEF_P1,
  parameter int P2      = DEF_P2,
  parameter int P3      = DEF_P3,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = DEF_CW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] button,
  output logic [3:0] shouldEat,
  output logic [3:0] notify
);

  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  logic [3:0]    due;
  logic [3:0]    clr;
  logic [3:0]    pending_next;
  logic [3:0]    notify_next;
  state_t        state_reg;
  state_t        state_next;
  logic [CW-1:0] wait_reg;
  logic [CW-1:0] wait_next;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_timer
      localparam int PER = (gi == 0) ? P0 : (gi == 1) ? P1 : (gi == 2) ? P2 : P3;
      dose_timer #(
        .CW     (CW),
        .PERIOD (PER)
      ) u_timer (
        .clk (clk),
        .rst (rst),
        .due (due[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    wait_next   = wait_reg;
    notify_next = '0;
    clr         = '0;
    if (state_reg == DRUG_ALARM || state_reg == NOTIFY) begin
      clr = button & shouldEat;
    end
    // A dose falling due this cycle overrides an acknowledge of the same bit.
    pending_next = (shouldEat & ~clr) | due;

    case (state_reg)
      CHECK_TIME: begin
        if (shouldEat != '0) begin
          state_next = DRUG_ALARM;
          wait_next  = '0;
        end
      end
      DRUG_ALARM: begin
        if (pending_next == '0) begin
          state_next = DONE;
        end else if (wait_reg == WAIT_LAST) begin
          state_next = NOTIFY;
        end else if (wait_reg != '1) begin
          wait_next = wait_reg + 1'b1;
        end
      end
      NOTIFY: begin
        notify_next = pending_next;
        if (pending_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = CHECK_TIME;
      end
      default: begin
        state_next = CHECK_TIME;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CHECK_TIME;
      wait_reg  <= '0;
      shouldEat <= '0;
      notify    <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      shouldEat <= pending_next;
      notify    <= notify_next;
    end
  end

endmodule

// File: tb/tb_medicine_machine_core.sv
// Directed bench for medicine_machine_core with default parameters; edge
// numbers in the checks count rising edges after rst is released.
module tb_medicine_machine_core;

  logic       clk;
  logic       rst;
  logic [3:0] button;
  logic [3:0] shouldEat;
  logic [3:0] notify;

  int tests_run;
  int tests_failed;

  medicine_machine_core dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .shouldEat (shouldEat),
    .notify    (notify)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    end else begin
      $display("[TB] ok   %s: %b", tag, actual);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst    = 1'b0;
    button = 4'b0000;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    button       = 4'b1101;

    // Reset held with buttons pressed
    repeat (2) @(posedge clk);
    #1;
    check("rst_shouldEat", 8'(shouldEat), 8'b0000);
    check("rst_notify", 8'(notify), 8'b0000);
    check("rst_state", 8'(dut.state_reg), 8'd0);
    release_rst();

    // No presses: doses accumulate and escalate
    tick(3);
    check("e3_shouldEat", 8'(shouldEat), 8'b0000);
    tick(1);
    check("e4_shouldEat", 8'(shouldEat), 8'b0001);
    check("e4_state", 8'(dut.state_reg), 8'd0);
    tick(1);
    check("e5_state", 8'(dut.state_reg), 8'd1);
    tick(1);
    check("e6_shouldEat", 8'(shouldEat), 8'b0011);
    tick(2);
    check("e8_shouldEat", 8'(shouldEat), 8'b0111);
    check("e8_notify", 8'(notify), 8'b0000);
    tick(1);
    check("e9_state", 8'(dut.state_reg), 8'd3);
    check("e9_notify", 8'(notify), 8'b0000);
    tick(1);
    check("e10_notify", 8'(notify), 8'b0111);
    tick(2);
    check("e12_shouldEat", 8'(shouldEat), 8'b1111);
    check("e12_notify", 8'(notify), 8'b1111);

    // Asynchronous reset in the middle of Notify
    #2;
    rst = 1'b1;
    #1;
    check("arst_shouldEat", 8'(shouldEat), 8'b0000);
    check("arst_notify", 8'(notify), 8'b0000);
    check("arst_state", 8'(dut.state_reg), 8'd0);
    @(posedge clk);
    release_rst();

    // Timers restart; ignored and valid acknowledges
    tick(3);
    check("r_e3_shouldEat", 8'(shouldEat), 8'b0000);
    tick(1);
    check("r_e4_shouldEat", 8'(shouldEat), 8'b0001);
    button = 4'b0001;                 // sampled in CheckTime: ignored
    tick(1);
    button = 4'b0000;
    check("r_e5_shouldEat", 8'(shouldEat), 8'b0001);
    check("r_e5_state", 8'(dut.state_reg), 8'd1);
    button = 4'b1000;                 // non-pending bit: ignored
    tick(1);
    button = 4'b0000;
    check("r_e6_shouldEat", 8'(shouldEat), 8'b0011);
    button = 4'b0011;
    tick(1);
    button = 4'b0000;
    check("r_e7_shouldEat", 8'(shouldEat), 8'b0000);
    check("r_e7_state", 8'(dut.state_reg), 8'd2);
    check("r_e7_notify", 8'(notify), 8'b0000);
    tick(1);
    check("r_e8_state", 8'(dut.state_reg), 8'd0);
    check("r_e8_shouldEat", 8'(shouldEat), 8'b0101);
    tick(1);
    check("r_e9_state", 8'(dut.state_reg), 8'd1);
    tick(4);
    check("r_e13_state", 8'(dut.state_reg), 8'd3);
    tick(1);
    check("r_e14_notify", 8'(notify), 8'b1111);

    // Press bit2 on the edge it falls due again: set wins
    tick(1);
    button = 4'b0100;
    tick(1);
    button = 4'b0000;
    check("r_e16_shouldEat", 8'(shouldEat), 8'b1111);
    check("r_e16_notify", 8'(notify), 8'b1111);
    button = 4'b1111;
    tick(1);
    button = 4'b0000;
    check("r_e17_shouldEat", 8'(shouldEat), 8'b0000);
    check("r_e17_notify", 8'(notify), 8'b0000);
    check("r_e17_state", 8'(dut.state_reg), 8'd2);
    tick(1);
    check("r_e18_state", 8'(dut.state_reg), 8'd0);
    check("r_e18_shouldEat", 8'(shouldEat), 8'b0010);
    check("r_e18_notify", 8'(notify), 8'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
